// File: rtl/alu_seq.sv
// alu_seq: registered ALU behind a valid/ready handshake, with iterative shift-add MUL and restoring DIVU.
// Define ALU_SEQ_MULH_EN to keep the full 2*WIDTH product so hi_sel can return the upper half.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             cin,
  input  logic             sign,
  input  logic             hi_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem_out,
  output logic             ofl,
  output logic             zero,
  output logic             div_zero
);

  localparam logic [3:0] OP_ROL  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_ROR  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SCO  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLE  = 4'd11;
  localparam logic [3:0] OP_SEQ  = 4'd12;
  localparam logic [3:0] OP_SRA  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_DIVU = 4'd15;

  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_SEQ_MULH_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next_state;

  logic [WIDTH-1:0]   w_a, w_b;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add, w_sub;
  logic [2*WIDTH-1:0] w_rol_full, w_ror_full;
  logic [WIDTH-1:0]   w_sra;
  logic               w_lt, w_eq;
  logic               w_add_sovf, w_sub_sovf;
  logic [WIDTH-1:0]   w_sc_result;
  logic               w_sc_ofl;
  logic               w_accept, w_is_multi;

  logic [WIDTH-1:0]   r_result, r_rem_out;
  logic               r_ofl, r_zero, r_div_zero;

  logic [PW-1:0]      r_acc, r_mcand, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier, r_divisor, r_quo, r_rem;
  logic [WIDTH-1:0]   w_quo_nxt, w_rem_nxt, w_mul_res, w_final;
  logic [WIDTH:0]     w_trial, w_trial_sub;
  logic               w_ge;
  logic [CW-1:0]      r_cnt;
  logic               r_is_mul;
  logic               w_unused;

  assign w_a = inv_a ? ~in_a : in_a;
  assign w_b = inv_b ? ~in_b : in_b;
  assign w_sh = w_b[SHW-1:0];

  assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, cin};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};

  // Rotates fall out of shifting a doubled copy of A.
  assign w_rol_full = {w_a, w_a} << w_sh;
  assign w_ror_full = {w_a, w_a} >> w_sh;
  assign w_sra      = $signed(w_a) >>> w_sh;

  assign w_lt = sign ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);
  assign w_eq = (w_a == w_b);

  assign w_add_sovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_add[WIDTH-1] != w_a[WIDTH-1]);
  assign w_sub_sovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sub[WIDTH-1] != w_a[WIDTH-1]);

  always_comb begin
    w_sc_result = '0;
    w_sc_ofl    = 1'b0;
    case (oper)
      OP_ROL: w_sc_result = w_rol_full[2*WIDTH-1:WIDTH];
      OP_SLL: w_sc_result = w_a << w_sh;
      OP_ROR: w_sc_result = w_ror_full[WIDTH-1:0];
      OP_SRL: w_sc_result = w_a >> w_sh;
      OP_ADD: begin
        w_sc_result = w_add[WIDTH-1:0];
        w_sc_ofl    = sign ? w_add_sovf : w_add[WIDTH];
      end
      OP_AND: w_sc_result = w_a & w_b;
      OP_OR:  w_sc_result = w_a | w_b;
      OP_XOR: w_sc_result = w_a ^ w_b;
      OP_SCO: w_sc_result = {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
      OP_SUB: begin
        w_sc_result = w_sub[WIDTH-1:0];
        w_sc_ofl    = sign ? w_sub_sovf : ~w_sub[WIDTH];
      end
      OP_SLT: w_sc_result = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLE: w_sc_result = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
      OP_SEQ: w_sc_result = {{(WIDTH-1){1'b0}}, w_eq};
      OP_SRA: w_sc_result = w_sra;
      default: w_sc_result = '0;
    endcase
  end

  // MUL and DIVU step in lockstep every BUSY cycle; r_is_mul picks which result lands.
  assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_trial     = {r_rem, r_quo[WIDTH-1]};
  assign w_ge        = (w_trial >= {1'b0, r_divisor});
  assign w_trial_sub = w_trial - {1'b0, r_divisor};
  assign w_rem_nxt   = w_ge ? w_trial_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_ge};

`ifdef ALU_SEQ_MULH_EN
  logic r_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi <= 1'b0;
    end else if (w_accept && w_is_multi) begin
      r_hi <= hi_sel;
    end
  end

  assign w_mul_res = r_hi ? w_acc_nxt[PW-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
  assign w_unused  = ^{w_rol_full[WIDTH-1:0], w_ror_full[2*WIDTH-1:WIDTH], w_trial_sub[WIDTH]};
`else
  assign w_mul_res = w_acc_nxt[WIDTH-1:0];
  assign w_unused  = ^{w_rol_full[WIDTH-1:0], w_ror_full[2*WIDTH-1:WIDTH], w_trial_sub[WIDTH], hi_sel};
`endif

  assign w_final = r_is_mul ? w_mul_res : w_quo_nxt;

  assign w_is_multi = (oper == OP_MUL) || (oper == OP_DIVU);
  assign in_ready   = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_is_multi ? BUSY : DONE;
      end
      BUSY: begin
        if (r_cnt == CW'(1)) w_next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_next_state = w_is_multi ? BUSY : DONE;
          else          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_rem_out  <= '0;
      r_ofl      <= 1'b0;
      r_zero     <= 1'b0;
      r_div_zero <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_is_mul   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        if (w_is_multi) begin
          r_cnt     <= CW'(WIDTH);
          r_is_mul  <= (oper == OP_MUL);
          r_acc     <= '0;
          r_mcand   <= PW'(w_a);
          r_mplier  <= w_b;
          r_divisor <= w_b;
          r_quo     <= w_a;
          r_rem     <= '0;
        end else begin
          r_result   <= w_sc_result;
          r_rem_out  <= '0;
          r_ofl      <= w_sc_ofl;
          r_zero     <= (w_sc_result == '0);
          r_div_zero <= 1'b0;
        end
      end else if (r_state == BUSY) begin
        r_cnt    <= r_cnt - CW'(1);
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_quo    <= w_quo_nxt;
        r_rem    <= w_rem_nxt;
        // A zero divisor needs no special case: every trial subtract succeeds,
        // giving an all-ones quotient and A shifted through as the remainder.
        if (r_cnt == CW'(1)) begin
          r_result   <= w_final;
          r_rem_out  <= r_is_mul ? '0 : w_rem_nxt;
          r_ofl      <= 1'b0;
          r_zero     <= (w_final == '0);
          r_div_zero <= !r_is_mul && (r_divisor == '0);
        end
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign rem_out   = r_rem_out;
  assign ofl       = r_ofl & out_valid;
  assign zero      = r_zero & out_valid;
  assign div_zero  = r_div_zero & out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for alu_seq (WIDTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  oper;
  logic [15:0] in_a, in_b;
  logic        inv_a, inv_b, cin, sign, hi_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result, rem_out;
  logic        ofl, zero, div_zero;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_mul_hi_a, exp_mul_hi_b;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .oper      (oper),
    .in_a      (in_a),
    .in_b      (in_b),
    .inv_a     (inv_a),
    .inv_b     (inv_b),
    .cin       (cin),
    .sign      (sign),
    .hi_sel    (hi_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rem_out   (rem_out),
    .ofl       (ofl),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one op at a falling edge, wait (bounded) for out_valid, check every output.
  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic c, input logic h, input logic ia, input logic ib,
                     input int lat, input logic [15:0] res, input logic [15:0] rem,
                     input logic of, input logic dz);
    int n;
    int busy;
    oper = op; in_a = a; in_b = b; sign = s; cin = c; hi_sel = h; inv_a = ia; inv_b = ib;
    in_valid = 1'b1;
    #1;
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    busy = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) busy++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy"}, busy, lat);
    chk({tag, ".res"}, {16'd0, result}, {16'd0, res});
    chk({tag, ".rem"}, {16'd0, rem_out}, {16'd0, rem});
    chk({tag, ".ofl"}, {31'd0, ofl}, {31'd0, of});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (res == 16'd0)});
    chk({tag, ".dz"}, {31'd0, div_zero}, {31'd0, dz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef ALU_SEQ_MULH_EN
    exp_mul_hi_a = 16'h0000;
    exp_mul_hi_b = 16'hFFFE;
`else
    exp_mul_hi_a = 16'hFFFF;
    exp_mul_hi_b = 16'h0001;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    oper = 4'd0; in_a = '0; in_b = '0; inv_a = 1'b0; inv_b = 1'b0;
    cin = 1'b0; sign = 1'b0; hi_sel = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.rdy", {31'd0, in_ready}, 32'd0);
    chk("rst.res", {16'd0, result}, 32'd0);
    chk("rst.flags", {29'd0, ofl, zero, div_zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.rdy", {31'd0, in_ready}, 32'd1);

    //  tag         op     a         b         s     c     h     ia    ib   lat  res       rem    ofl   dz
    run("add_sovf", 4'd4,  16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h8000, 16'd0, 1'b1, 1'b0);
    run("sub_eq",   4'd9,  16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 16'd0, 1'b0, 1'b0);
    run("slt_s",    4'd10, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0001, 16'd0, 1'b0, 1'b0);
    run("slt_u",    4'd10, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 16'd0, 1'b0, 1'b0);
    run("add_c",    4'd4,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 16'd0, 1'b1, 1'b0);
    run("sub_bor",  4'd9,  16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'hFFFF, 16'd0, 1'b1, 1'b0);
    run("sub_sovf", 4'd9,  16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h7FFF, 16'd0, 1'b1, 1'b0);
    run("sle",      4'd11, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0001, 16'd0, 1'b0, 1'b0);
    run("seq",      4'd12, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 16'd0, 1'b0, 1'b0);
    run("sco",      4'd8,  16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0001, 16'd0, 1'b0, 1'b0);
    run("and_ib",   4'd5,  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h00F0, 16'd0, 1'b0, 1'b0);
    run("xor_ia",   4'd7,  16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'hF00F, 16'd0, 1'b0, 1'b0);
    run("or",       4'd6,  16'h1200, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1234, 16'd0, 1'b0, 1'b0);
    run("rol",      4'd0,  16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0003, 16'd0, 1'b0, 1'b0);
    run("ror",      4'd2,  16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1000, 16'd0, 1'b0, 1'b0);
    run("sll",      4'd1,  16'h0001, 16'h0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0008, 16'd0, 1'b0, 1'b0);
    run("srl",      4'd3,  16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0001, 16'd0, 1'b0, 1'b0);
    run("sra_pos",  4'd13, 16'h4000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1000, 16'd0, 1'b0, 1'b0);
    run("mul",      4'd14, 16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    run("mul_hi",   4'd14, 16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16, exp_mul_hi_a, 16'd0, 1'b0, 1'b0);
    run("mul_ffhi", 4'd14, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16, exp_mul_hi_b, 16'd0, 1'b0, 1'b0);
    run("mul_fflo", 4'd14, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'h0001, 16'd0, 1'b0, 1'b0);
    run("divu",     4'd15, 16'd100,  16'd7,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'd14,   16'd2, 1'b0, 1'b0);

    // Let the last result drain, then hold a divide-by-zero result under backpressure.
    @(negedge clk);
    chk("drain.vld", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    run("div0",     4'd15, 16'd5,    16'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16'hFFFF, 16'd5, 1'b0, 1'b1);

    oper = 4'd4; in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.vld", {31'd0, out_valid}, 32'd1);
      chk("hold.rdy", {31'd0, in_ready}, 32'd0);
      chk("hold.res", {16'd0, result}, 32'h0000FFFF);
      chk("hold.rem", {16'd0, rem_out}, 32'd5);
      chk("hold.dz",  {31'd0, div_zero}, 32'd1);
    end

    oper = 4'd13; in_a = 16'h8000; in_b = 16'h0004; out_ready = 1'b1;
    #1;
    chk("b2b.rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.vld", {31'd0, out_valid}, 32'd1);
    chk("b2b.res", {16'd0, result}, 32'h0000F800);
    chk("b2b.rem", {16'd0, rem_out}, 32'd0);
    chk("b2b.dz",  {31'd0, div_zero}, 32'd0);

    // Start a divide back-to-back, then reset on its eighth busy cycle.
    oper = 4'd15; in_a = 16'd100; in_b = 16'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid.vld", {31'd0, out_valid}, 32'd0);
    chk("mid.rdy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst.vld", {31'd0, out_valid}, 32'd0);
    chk("mrst.rdy", {31'd0, in_ready}, 32'd1);
    chk("mrst.res", {16'd0, result}, 32'd0);
    chk("mrst.rem", {16'd0, rem_out}, 32'd0);
    chk("mrst.flags", {29'd0, ofl, zero, div_zero}, 32'd0);

    run("add_after", 4'd4, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'd5, 16'd0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("quiet.vld", {31'd0, out_valid}, 32'd0);
    chk("quiet.res", {16'd0, result}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
